// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - shared multi-port instruction store with power-up clear and runtime program load
module imem_loadable #(
    parameter int                 NUM_C     = 4,
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 16,
    parameter int                 DEPTH     = 1024,
    parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(43)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_C-1:0]          req,
    input  logic [NUM_C*ADDR_W-1:0]   addr,
    output logic [NUM_C*DATA_W-1:0]   data_out,
    output logic [NUM_C-1:0]          rvalid,
    output logic [NUM_C-1:0]          oor,
    output logic                      ready,
    input  logic                      load_start,
    input  logic                      load_valid,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [DATA_W-1:0]         load_data,
    input  logic                      load_last,
    output logic                      load_ready,
    output logic [ADDR_W:0]           load_count,
    output logic                      load_err
);

    localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = ADDR_W + 1;
    localparam logic [CW-1:0]   DEPTH_X  = CW'(DEPTH);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       clr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                load_in_range;
    logic                mem_we;
    logic [IW-1:0]       mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                fetch_en;
    logic                enter_load;

    // Full-width unsigned compare: addresses beyond DEPTH never alias onto low words.
    assign load_in_range = ({1'b0, load_addr} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (clr_idx == LAST_IDX)        state_nx = ST_LOAD;
            ST_LOAD:  if (load_valid && load_last)    state_nx = ST_RUN;
            ST_RUN:   if (load_start)                 state_nx = ST_LOAD;
            default:                                  state_nx = ST_CLEAR;
        endcase
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = clr_idx;
        mem_wdata  = FILL_WORD;
        fetch_en   = 1'b0;
        enter_load = (state != ST_LOAD) && (state_nx == ST_LOAD);
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx;
                mem_wdata = FILL_WORD;
            end
            ST_LOAD: begin
                mem_we    = load_valid && load_in_range;
                mem_waddr = load_addr[IW-1:0];
                mem_wdata = load_data;
            end
            ST_RUN: begin
                fetch_en  = 1'b1;
            end
            default: begin
                mem_we    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + IW'(1);
        end
    end

    // Writes happen only in CLEAR/LOAD and reads only in RUN, so no read/write collision exists.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready      <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            ready      <= (state_nx == ST_RUN);
            load_ready <= (state_nx == ST_LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else if (enter_load) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else if (state == ST_LOAD && load_valid) begin
            if (load_in_range) begin
                load_count <= load_count + CW'(1);
            end else begin
                load_err   <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_C; g++) begin : g_port
        logic [ADDR_W-1:0] port_addr;
        logic              port_in_range;
        logic [DATA_W-1:0] port_q;
        logic              port_v;
        logic              port_o;

        assign port_addr     = addr[g*ADDR_W +: ADDR_W];
        assign port_in_range = ({1'b0, port_addr} < DEPTH_X);

        // Unserved cycles keep the last word so a stalled fetch stage sees a stable bus.
        always_ff @(posedge clk) begin
            if (rst) begin
                port_q <= '0;
                port_v <= 1'b0;
                port_o <= 1'b0;
            end else if (fetch_en && req[g]) begin
                port_v <= 1'b1;
                port_o <= !port_in_range;
                port_q <= port_in_range ? mem[port_addr[IW-1:0]] : FILL_WORD;
            end else begin
                port_v <= 1'b0;
                port_o <= 1'b0;
            end
        end

        assign data_out[g*DATA_W +: DATA_W] = port_q;
        assign rvalid[g]                    = port_v;
        assign oor[g]                       = port_o;
    end

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - self-checking bench for imem_loadable
module tb_imem_loadable;

    localparam int NUM_C  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam logic [15:0] FILL = 16'd43;

    logic                    clk;
    logic                    rst;
    logic [NUM_C-1:0]        req;
    logic [NUM_C*ADDR_W-1:0] addr;
    logic [NUM_C*DATA_W-1:0] data_out;
    logic [NUM_C-1:0]        rvalid;
    logic [NUM_C-1:0]        oor;
    logic                    ready;
    logic                    load_start;
    logic                    load_valid;
    logic [ADDR_W-1:0]       load_addr;
    logic [DATA_W-1:0]       load_data;
    logic                    load_last;
    logic                    load_ready;
    logic [ADDR_W:0]         load_count;
    logic                    load_err;

    int checks = 0;
    int errors = 0;

    imem_loadable #(
        .NUM_C(NUM_C), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .data_out(data_out),
        .rvalid(rvalid), .oor(oor), .ready(ready), .load_start(load_start),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
        .load_err(load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = clearing, 1 = loading, 2 = running.
    bit          m_on = 1'b0;
    int          m_mode;
    int          m_clr;
    logic [15:0] m_mem [DEPTH];
    logic [63:0] e_data;
    logic [3:0]  e_rvalid;
    logic [3:0]  e_oor;
    logic        e_ready;
    logic        e_lready;
    int          e_cnt;
    logic        e_err;

    always @(posedge clk) begin
        if (rst) begin
            m_on     = 1'b1;
            m_mode   = 0;
            m_clr    = 0;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = FILL;
            e_data   = '0;
            e_rvalid = '0;
            e_oor    = '0;
            e_ready  = 1'b0;
            e_lready = 1'b0;
            e_cnt    = 0;
            e_err    = 1'b0;
        end else if (m_on) begin
            for (int i = 0; i < NUM_C; i++) begin
                int a;
                a = int'(addr[i*ADDR_W +: ADDR_W]);
                if (m_mode == 2 && req[i]) begin
                    e_rvalid[i] = 1'b1;
                    e_oor[i]    = (a >= DEPTH);
                    e_data[i*DATA_W +: DATA_W] = (a >= DEPTH) ? FILL : m_mem[a];
                end else begin
                    e_rvalid[i] = 1'b0;
                    e_oor[i]    = 1'b0;
                end
            end
            case (m_mode)
                0: begin
                    m_clr++;
                    if (m_clr == DEPTH) begin
                        m_mode = 1;
                        e_cnt  = 0;
                        e_err  = 1'b0;
                    end
                end
                1: if (load_valid) begin
                    if (int'(load_addr) < DEPTH) begin
                        m_mem[int'(load_addr)] = load_data;
                        e_cnt++;
                    end else begin
                        e_err = 1'b1;
                    end
                    if (load_last) m_mode = 2;
                end
                default: if (load_start) begin
                    m_mode = 1;
                    e_cnt  = 0;
                    e_err  = 1'b0;
                end
            endcase
            e_ready  = (m_mode == 2);
            e_lready = (m_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_data_out",   data_out,   e_data);
            chk("m_rvalid",     rvalid,     e_rvalid);
            chk("m_oor",        oor,        e_oor);
            chk("m_ready",      ready,      e_ready);
            chk("m_load_ready", load_ready, e_lready);
            chk("m_load_count", load_count, e_cnt);
            chk("m_load_err",   load_err,   e_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] r, input logic [63:0] a);
        req  = r;
        addr = a;
        tick();
        req  = '0;
    endtask

    task automatic wait_clear(output int n, output bit saw_ready);
        n = 0;
        saw_ready = 1'b0;
        while (!load_ready && n < 3000) begin
            if (ready) saw_ready = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit saw;
        rst = 1'b1; req = '0; addr = '0; load_start = 1'b0; load_valid = 1'b0;
        load_addr = '0; load_data = '0; load_last = 1'b0;
        tick();
        tick();
        chk("rst_data_out",   data_out,   64'h0);
        chk("rst_rvalid",     rvalid,     4'h0);
        chk("rst_ready",      ready,      1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_load_count", load_count, 17'd0);
        chk("rst_load_err",   load_err,   1'b0);
        rst = 1'b0;

        wait_clear(n, saw);
        chk("clear_len",       n,   1024);
        chk("clear_no_ready",  saw, 1'b0);
        load_word(16'd0, 16'd6, 1'b1);
        chk("run_ready", ready, 1'b1);
        fetch(4'h1, 64'd5);
        chk("cleared_word",  data_out[15:0], 16'd43);
        chk("cleared_oor",   oor[0],         1'b0);
        chk("cleared_valid", rvalid[0],      1'b1);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("reenter_count", load_count, 17'd0);
        load_word(16'd0, 16'd33, 1'b0);
        load_word(16'd1, 16'd38, 1'b0);
        load_word(16'd2, 16'd6, 1'b0);
        load_word(16'd1024, 16'd99, 1'b0);
        chk("oor_load_count", load_count, 17'd3);
        chk("oor_load_err",   load_err,   1'b1);
        load_word(16'd3, 16'd0, 1'b1);
        chk("load_count4", load_count, 17'd4);

        fetch(4'hf, {4{16'd2}});
        chk("par_data",  data_out, {4{16'd6}});
        chk("par_valid", rvalid,   4'hf);
        fetch(4'hf, {16'd2000, 16'd1, 16'd1, 16'd1});
        chk("oor_data",  data_out, {16'd43, 16'd38, 16'd38, 16'd38});
        chk("oor_flags", oor,      4'b1000);
        chk("oor_valid", rvalid,   4'hf);
        tick();
        chk("idle_valid", rvalid,          4'h0);
        chk("idle_hold",  data_out[15:0],  16'd38);

        req = 4'h1; addr = 64'd0; load_start = 1'b1;
        tick();
        req = '0; load_start = 1'b0;
        chk("reload_fetch_valid", rvalid,         4'h1);
        chk("reload_fetch_data",  data_out[15:0], 16'd33);
        chk("reload_ready",       ready,          1'b0);
        chk("reload_load_ready",  load_ready,     1'b1);
        fetch(4'hf, 64'd0);
        chk("load_no_fetch", rvalid, 4'h0);
        load_word(16'd0, 16'd5, 1'b1);
        fetch(4'h1, 64'd0);
        chk("reload_data", data_out[15:0], 16'd5);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_word(16'd10, 16'd100, 1'b0);
        load_word(16'd11, 16'd200, 1'b0);
        chk("midload_count", load_count, 17'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count",      load_count, 17'd0);
        chk("midrst_load_ready", load_ready, 1'b0);
        chk("midrst_ready",      ready,      1'b0);
        wait_clear(n, saw);
        chk("reclear_len", n, 1024);
        load_word(16'd12, 16'd7, 1'b1);
        fetch(4'hf, {16'd0, 16'd12, 16'd11, 16'd10});
        chk("after_reset_data", data_out, {16'd43, 16'd7, 16'd43, 16'd43});

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
